// File: rtl/keccak_state_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keccak_state_bank: Keccak sponge state with lane-serial absorb/squeeze.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module keccak_state_bank #(
  parameter int WIDTH = 1600,
  parameter int LANE = 64,
  parameter int RATE_LANES = 21,
  parameter logic [WIDTH-1:0] INIT = '0,
  localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] state_in,
  input  logic [1:0]       mode,
  input  logic [LANE-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANE-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] state_out,
  output logic [IDX_W-1:0] lane_idx,
  output logic             blk_full
);

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_ABSORB  = 2'b01;
  localparam logic [1:0] MODE_SQUEEZE = 2'b10;
  localparam int SEL_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  if ((WIDTH % LANE) != 0 || RATE_LANES < 1 || RATE_LANES > WIDTH / LANE) begin : g_param_check
    $error("keccak_state_bank: illegal WIDTH/LANE/RATE_LANES combination");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [1:0]       prev_mode;
  logic [IDX_W-1:0] idx_q;
  logic             full_q;
  logic             switch_now;
  logic             absorb_xfer;
  logic             squeeze_xfer;
  logic [SEL_W-1:0] base;
  logic [LANE-1:0]  cur_lane;

  // A direct absorb<->squeeze turnaround costs one idle cycle and rewinds the lane counter.
  assign switch_now = ((prev_mode == MODE_ABSORB) && (mode == MODE_SQUEEZE)) ||
                      ((prev_mode == MODE_SQUEEZE) && (mode == MODE_ABSORB));

  assign base     = SEL_W'(idx_q) * SEL_W'(LANE);
  assign cur_lane = state_q[base +: LANE];

  assign in_ready  = rst & (mode == MODE_ABSORB) & ~full_q & ~clr & ~load & ~switch_now;
  assign out_valid = rst & (mode == MODE_SQUEEZE) & ~full_q & ~switch_now;
  assign out_data  = cur_lane;

  assign absorb_xfer  = in_valid & in_ready;
  assign squeeze_xfer = out_valid & out_ready & ~clr & ~load;

  always_comb begin
    state_d = state_q;
    if (absorb_xfer) begin
      state_d[base +: LANE] = cur_lane ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT;
      idx_q     <= '0;
      full_q    <= 1'b0;
      prev_mode <= MODE_HOLD;
    end else begin
      prev_mode <= mode;
      if (clr) begin
        state_q <= INIT;
        idx_q   <= '0;
        full_q  <= 1'b0;
      end else if (load) begin
        state_q <= state_in;
        idx_q   <= '0;
        full_q  <= 1'b0;
      end else if (switch_now) begin
        idx_q <= '0;
      end else if (absorb_xfer || squeeze_xfer) begin
        state_q <= state_d;
        if (idx_q == LAST_IDX) begin
          idx_q  <= '0;
          full_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign state_out = state_q;
  assign lane_idx  = idx_q;
  assign blk_full  = full_q;

endmodule
`default_nettype wire

// File: tb/tb_keccak_state_bank.sv
`default_nettype none
// Bench for keccak_state_bank: lane-array reference model plus directed literal checks.
module tb_keccak_state_bank;
  localparam int WIDTH = 1600;
  localparam int LANE  = 64;
  localparam int RATE  = 21;
  localparam int NL    = WIDTH / LANE;

  typedef logic [NL-1:0][LANE-1:0] lanes_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] state_in = '0;
  logic [1:0]       mode = 2'd0;
  logic [LANE-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANE-1:0]  out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] state_out;
  logic [4:0]       lane_idx;
  logic             blk_full;

  always #5 clk = ~clk;

  keccak_state_bank #(.WIDTH(WIDTH), .LANE(LANE), .RATE_LANES(RATE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .state_in(state_in), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .lane_idx(lane_idx), .blk_full(blk_full)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the state as an array of lanes plus a lane counter.
  logic [LANE-1:0] m_lane [NL];
  int m_idx;
  bit m_full;
  int m_prev;

  lanes_t so;
  lanes_t si;
  assign so = state_out;
  assign si = state_in;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_lanes(string name);
    int bad;
    bad = -1;
    checks++;
    for (int k = NL - 1; k >= 0; k--)
      if (so[k] !== m_lane[k]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: lane %0d got %h expected %h", name, bad, so[bad], m_lane[bad]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NL; k++) m_lane[k] = '0;
    m_idx = 0;
    m_full = 0;
    m_prev = 0;
  endtask

  function automatic bit m_switch();
    return (m_prev == 1 && mode == 2'd2) || (m_prev == 2 && mode == 2'd1);
  endfunction

  function automatic bit m_in_ready();
    return rst && mode == 2'd1 && !m_full && !clr && !load && !m_switch();
  endfunction

  function automatic bit m_out_valid();
    return rst && mode == 2'd2 && !m_full && !m_switch();
  endfunction

  task automatic m_advance();
    m_idx++;
    if (m_idx == RATE) begin
      m_idx = 0;
      m_full = 1;
    end
  endtask

  task automatic model_edge();
    bit ir, ov, sw;
    ir = m_in_ready();
    ov = m_out_valid();
    sw = m_switch();
    if (!rst) begin
      model_reset();
    end else begin
      if (clr) begin
        for (int k = 0; k < NL; k++) m_lane[k] = '0;
        m_idx = 0;
        m_full = 0;
      end else if (load) begin
        for (int k = 0; k < NL; k++) m_lane[k] = si[k];
        m_idx = 0;
        m_full = 0;
      end else if (sw) begin
        m_idx = 0;
      end else if (in_valid && ir) begin
        m_lane[m_idx] = m_lane[m_idx] ^ in_data;
        m_advance();
      end else if (out_ready && ov) begin
        m_advance();
      end
      m_prev = int'(mode);
    end
  endtask

  task automatic compare();
    chk_lanes("state_out");
    chk("lane_idx", 64'(lane_idx), 64'(m_idx));
    chk("blk_full", 64'(blk_full), 64'(m_full));
    chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_out_valid()));
    chk("out_data", out_data, m_lane[m_idx]);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are compared on the falling edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_state();
    for (int k = 0; k < WIDTH / 32; k++) state_in[k*32 +: 32] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANE-1:0] samp [6];
    logic [LANE-1:0] first_data;
    lanes_t held;
    int n;
    bit tog;

    model_reset();
    mode = 2'd1;
    in_valid = 1'b1;
    in_data = '1;
    #1 rst = 1'b0;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset lane_idx", 64'(lane_idx), 64'd0);
    chk("reset state_or", 64'(|state_out), 64'd0);
    cycle();
    cycle();
    rst = 1'b1;
    mode = 2'd0;
    in_valid = 1'b0;

    // Full block absorb of k+1 into lane k.
    clr = 1'b1; cycle(); clr = 1'b0;
    mode = 2'd1;
    in_valid = 1'b1;
    for (int k = 0; k < RATE; k++) begin
      in_data = 64'(k + 1);
      cycle();
    end
    in_data = {$urandom, $urandom};
    #3;
    chk("full blk_full", 64'(blk_full), 64'd1);
    chk("full in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < NL; k++)
      chk("full lane", so[k], (k < RATE) ? 64'(k + 1) : 64'd0);
    cycle();
    mode = 2'd0;
    in_valid = 1'b0;

    // XOR into loaded state with in_valid toggling.
    rand_state();
    state_in[3*LANE +: LANE] = 64'hFFFF_0000_FFFF_0000;
    load = 1'b1; cycle(); load = 1'b0;
    mode = 2'd1;
    n = 0;
    tog = 1'b1;
    for (int g = 0; g < 20 && n < 4; g++) begin
      in_valid = tog;
      in_data = (m_idx == 3) ? 64'h0F0F_0F0F_0F0F_0F0F : {$urandom, $urandom};
      if (in_valid && m_in_ready()) n++;
      cycle();
      tog = ~tog;
    end
    chk("xor lane3", so[3], 64'hF0F0_0F0F_F0F0_0F0F);
    chk("xor lane_idx", 64'(lane_idx), 64'd4);
    in_valid = 1'b0;
    mode = 2'd0;

    // Squeeze of lanes 0xA5<<k with sparse out_ready.
    for (int k = 0; k < NL; k++) state_in[k*LANE +: LANE] = 64'hA5 << k;
    load = 1'b1; cycle(); load = 1'b0;
    mode = 2'd2;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c % 2) == 1;
      #3;
      samp[c] = out_data;
      cycle();
    end
    out_ready = 1'b0;
    chk("sq data0", samp[0], 64'hA5);
    chk("sq data1", samp[1], 64'hA5);
    chk("sq data2", samp[2], 64'h14A);
    chk("sq data3", samp[3], 64'h14A);
    chk("sq data4", samp[4], 64'h294);
    chk("sq data5", samp[5], 64'h294);
    chk("sq lane_idx", 64'(lane_idx), 64'd3);

    // Priority: clr beats load beats absorb.
    mode = 2'd1;
    rand_state();
    clr = 1'b1; load = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    cycle();
    chk("prio clr state_or", 64'(|state_out), 64'd0);
    clr = 1'b0;
    rand_state();
    held = state_in;
    cycle();
    chk("prio load lane0", so[0], held[0]);
    chk("prio load lane20", so[20], held[20]);
    chk("prio load lane_idx", 64'(lane_idx), 64'd0);
    chk("prio load blk_full", 64'(blk_full), 64'd0);
    load = 1'b0;
    in_valid = 1'b0;

    // Absorb -> squeeze turnaround.
    clr = 1'b1; cycle(); clr = 1'b0;
    in_valid = 1'b1;
    first_data = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      in_data = (k == 0) ? first_data : {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    mode = 2'd2;
    #3;
    chk("switch out_valid", 64'(out_valid), 64'd0);
    cycle();
    #3;
    chk("switch2 out_valid", 64'(out_valid), 64'd1);
    chk("switch2 out_data", out_data, first_data);
    chk("switch2 lane_idx", 64'(lane_idx), 64'd0);
    chk("switch2 blk_full", 64'(blk_full), 64'd0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 199);
      clr = (n < 2);
      load = (n >= 2 && n < 4);
      if (load) rand_state();
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_data = {$urandom, $urandom};
      cycle();
    end
    clr = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of an absorb.
    mode = 2'd0;
    clr = 1'b1; cycle(); clr = 1'b0;
    mode = 2'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = {$urandom, $urandom} | 64'd1;
      cycle();
    end
    chk("pre-reset lane_idx", 64'(lane_idx), 64'd5);
    #2 rst = 1'b0;
    #1;
    chk("async state_or", 64'(|state_out), 64'd0);
    chk("async lane_idx", 64'(lane_idx), 64'd0);
    chk("async blk_full", 64'(blk_full), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd0);
    model_reset();
    cycle();
    rst = 1'b1;
    mode = 2'd0;
    in_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
